id_ex_stage: RTL

//  ID->EX pipeline register of the 5-stage MIPS core. Sits directly downstream of Register:

---
 rtl/id_ex_stage.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register for the 5-stage MIPS core.
// Captures Register operands and decoded ID fields and presents them to EX one cycle later.
// Detects load-use hazards: it stalls PC and IF/ID and inserts a bubble.
// A taken branch or jump (flush) squashes the instruction entering EX.
// Optional feature macro: WB_BYPASS_EN. When defined, operands are forwarded from the
// WB write port when WB writes the same register in the same cycle.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clock_in,
  input  logic          reset,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_readData1,
  input  logic [DW-1:0] id_readData2,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_pc4,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [8:0]    id_ctrl,
  input  logic          wb_regWrite,
  input  logic [RW-1:0] wb_writeReg,
  input  logic [DW-1:0] wb_writeData,
  output logic          pcWrite,
  output logic          ifidWrite,
  output logic          ex_valid,
  output logic [DW-1:0] ex_readData1,
  output logic [DW-1:0] ex_readData2,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc4,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic [8:0]    ex_ctrl,
  output logic [31:0]   stall_cnt
);

  // Bit position of memRead in {regDst,aluSrc,memToReg,regWrite,memRead,memWrite,branch,aluOp[1:0]}
  localparam int CTRL_MEMREAD = 4;

  logic          valid_q, valid_d;
  logic [DW-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc4_q, pc4_d;
  logic [RW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [8:0]    ctrl_q, ctrl_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          hazard_s;
  logic [DW-1:0] op1_s, op2_s;

  // Load-use hazard: the load in EX targets a register the ID instruction reads (never r0)
  always_comb begin
    hazard_s = valid_q & ctrl_q[CTRL_MEMREAD] & id_valid & (rt_q != {RW{1'b0}}) &
               ((rt_q == id_rs) | (rt_q == id_rt));
  end

  assign pcWrite   = ~hazard_s;
  assign ifidWrite = ~hazard_s;

`ifdef WB_BYPASS_EN
  // Forward the WB write value when it targets an operand register read this cycle
  always_comb begin
    op1_s = id_readData1;
    op2_s = id_readData2;
    if (wb_regWrite && (wb_writeReg != {RW{1'b0}}) && (wb_writeReg == id_rs)) begin
      op1_s = wb_writeData;
    end else begin
      op1_s = id_readData1;
    end
    if (wb_regWrite && (wb_writeReg != {RW{1'b0}}) && (wb_writeReg == id_rt)) begin
      op2_s = wb_writeData;
    end else begin
      op2_s = id_readData2;
    end
  end
`else
  // Without bypass the WB port is not observed; operands come straight from Register
  logic unused_wb_s;
  assign unused_wb_s = ^{wb_regWrite, wb_writeReg, wb_writeData};

  // Operands pass through unchanged
  always_comb begin
    op1_s = id_readData1;
    op2_s = id_readData2;
  end
`endif

  // Next-state selection: flush beats hazard; both insert an all-zero bubble
  always_comb begin
    valid_d = id_valid;
    rd1_d   = op1_s;
    rd2_d   = op2_s;
    imm_d   = id_imm;
    pc4_d   = id_pc4;
    rs_d    = id_rs;
    rt_d    = id_rt;
    rd_d    = id_rd;
    ctrl_d  = id_valid ? id_ctrl : 9'd0;
    cnt_d   = cnt_q;
    if (flush || hazard_s) begin
      valid_d = 1'b0;
      rd1_d   = {DW{1'b0}};
      rd2_d   = {DW{1'b0}};
      imm_d   = {DW{1'b0}};
      pc4_d   = {DW{1'b0}};
      rs_d    = {RW{1'b0}};
      rt_d    = {RW{1'b0}};
      rd_d    = {RW{1'b0}};
      ctrl_d  = 9'd0;
      if (!flush) begin
        cnt_d = cnt_q + 32'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline register with synchronous reset
  always_ff @(posedge clock_in) begin
    if (reset) begin
      valid_q <= 1'b0;
      rd1_q   <= {DW{1'b0}};
      rd2_q   <= {DW{1'b0}};
      imm_q   <= {DW{1'b0}};
      pc4_q   <= {DW{1'b0}};
      rs_q    <= {RW{1'b0}};
      rt_q    <= {RW{1'b0}};
      rd_q    <= {RW{1'b0}};
      ctrl_q  <= 9'd0;
      cnt_q   <= 32'd0;
    end else begin
      valid_q <= valid_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc4_q   <= pc4_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_readData1 = rd1_q;
  assign ex_readData2 = rd2_q;
  assign ex_imm       = imm_q;
  assign ex_pc4       = pc4_q;
  assign ex_rs        = rs_q;
  assign ex_rt        = rt_q;
  assign ex_rd        = rd_q;
  assign ex_ctrl      = ctrl_q;
  assign stall_cnt    = cnt_q;

endmodule
